// File: rtl/clk_switch_ctrl.sv
// Break-before-make sequencer for a glitch-free clock mux: gate the current
// source off, wait for its ack, settle, switch the select, then gate the target on.
module clk_switch_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1,
  parameter int RST_SEL = 0,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  input  logic [NUM_SRC-1:0] en_ack,
  output logic [NUM_SRC-1:0] en_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFF,
    S_SETTLE,
    S_ON
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [NUM_SRC-1:0] en_out_q, en_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q;
  logic               req_invalid;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = NUM_SRC'(1) << s;
  endfunction

  // Widened compare so the check stays meaningful when NUM_SRC is a power of two
  assign req_invalid = ({1'b0, req_sel} >= (SEL_W+1)'(NUM_SRC));

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cur_sel_d = cur_sel_q;
    en_out_d  = en_out_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_invalid) begin
            err_d = 1'b1;
          end else if (req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d    = req_sel;
            en_out_d = '0;
            cnt_d    = '0;
            state_d  = S_OFF;
          end
        end
      end
      S_OFF: begin
        en_out_d = '0;
        if (!en_ack[cur_sel_q]) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Old source never stopped: hand its gate back and drop the request
          en_out_d = onehot(cur_sel_q);
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        en_out_d = '0;
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cur_sel_d = tgt_q;
          cnt_d     = '0;
          state_d   = S_ON;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ON: begin
        en_out_d = onehot(tgt_q);
        // Only trust the ack once our enable has actually been presented
        if (en_out_q[tgt_q] && en_ack[tgt_q]) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= SEL_W'(RST_SEL);
      cur_sel_q <= SEL_W'(RST_SEL);
      en_out_q  <= NUM_SRC'(1) << RST_SEL;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cur_sel_q <= cur_sel_d;
      en_out_q  <= en_out_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= (state_d == S_IDLE);
    end
  end

  assign req_ready = ready_q;
  assign busy      = ~ready_q;
  assign en_out    = en_out_q;
  assign cur_sel   = cur_sel_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
